// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing scheduler.
package mult_share_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ID_W_MAX   = 4;
    localparam int PROD_W_MAX = 2 * WIDTH_DEF;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Sized for the widest configuration; narrower builds use the low bits.
    typedef struct packed {
        logic [ID_W_MAX-1:0]   id;
        logic [PROD_W_MAX-1:0] product;
    } rsp_entry_t;

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_share_rsp_fifo.sv
// Synchronous response FIFO of rsp_entry_t with a registered head entry.
// DEPTH must be a power of two (>= 2); the caller never pushes when full or pops when empty.
module mult_share_rsp_fifo
    import mult_share_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = id_w(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  rsp_entry_t       din,
    input  logic             pop,
    output rsp_entry_t       dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    rsp_entry_t       mem_q [DEPTH];
    rsp_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one registered signed multiplier among NUM_REQ requesters.
// Optional perf counters (perf_issued, perf_stall) are built when MULT_SHARE_SCHED_PERF_EN is defined.
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = WIDTH_DEF,
    parameter  int MUL_LAT   = 2,
    parameter  int RSP_DEPTH = 4,
    localparam int ID_W      = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_p,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product
`ifdef MULT_SHARE_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_issued,
    output logic [31:0]              perf_stall
`endif
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  scan_id, grant_id;
    logic             grant_valid, can_issue, pop;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tag_t             tag_q [MUL_LAT];
    tag_t             tag_d [MUL_LAT];
    rsp_entry_t       push_entry, fifo_dout;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_fifo_bits;

    // cnt_q counts in-flight plus buffered ops, so a full count means no FIFO slot is left.
    assign can_issue = (cnt_q < CNT_W'(RSP_DEPTH)) && !rst;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        req_ready   = '0;
        mul_a       = '0;
        mul_b       = '0;
        rr_ptr_d    = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_id = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (can_issue && !grant_valid && req_valid[scan_id]) begin
                grant_valid = 1'b1;
                grant_id    = scan_id;
            end
        end
        if (grant_valid) begin
            req_ready[grant_id] = 1'b1;
            mul_a               = req_a[int'(grant_id)*WIDTH +: WIDTH];
            mul_b               = req_b[int'(grant_id)*WIDTH +: WIDTH];
            rr_ptr_d            = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

    always_comb begin
        tag_d[0].valid = grant_valid;
        tag_d[0].id    = ID_W_MAX'(grant_id);
        for (int s = 1; s < MUL_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        cnt_d = cnt_q;
        if (grant_valid && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!grant_valid && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        push_entry.id      = tag_q[MUL_LAT-1].id;
        push_entry.product = PROD_W_MAX'(mul_p);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
        end
    end

    // The last tag stage lines up with mul_p, so its valid bit is the FIFO push.
    mult_share_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_q[MUL_LAT-1].valid),
        .din   (push_entry),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rsp_valid        = !fifo_empty;
    assign rsp_id           = fifo_empty ? '0 : fifo_dout.id[ID_W-1:0];
    assign rsp_product      = fifo_empty ? '0 : fifo_dout.product[2*WIDTH-1:0];
    assign unused_fifo_bits = ^fifo_dout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_count <= cnt_q);
        end
    end

`ifdef MULT_SHARE_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q + {31'd0, grant_valid};
        perf_stall_d  = perf_stall_q + {31'd0, (|req_valid) && !can_issue};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mult_share_sched.sv
// Self-checking bench for mult_share_sched: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed grant orders, products and latencies.
module tb_mult_share_sched;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 32;
    localparam int MUL_LAT   = 2;
    localparam int RSP_DEPTH = 4;
    localparam int ID_W      = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
    logic [WIDTH-1:0]         mul_a, mul_b;
    logic [2*WIDTH-1:0]       mul_p;
    logic                     rsp_valid, rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [2*WIDTH-1:0]       rsp_product;
`ifdef MULT_SHARE_SCHED_PERF_EN
    logic [31:0]              perf_issued, perf_stall;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        int          arr;
        int          id;
        logic [63:0] prod;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          model_rr = 0;
    op_t         req_q [NUM_REQ][$];
    exp_t        model_q [$];
    int          grant_cyc [$];
    int          grant_id_log [$];
    int          rsp_cyc [$];
    int          rsp_id_log [$];
    logic [63:0] rsp_prod_log [$];
    logic signed [63:0] mul_s1 = '0, mul_s2 = '0;

    always #5 clk = ~clk;

    mult_share_sched #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MUL_LAT   (MUL_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_p       (mul_p),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product)
`ifdef MULT_SHARE_SCHED_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    // Two-stage registered signed multiplier standing in for the shared wrapper instance.
    always @(posedge clk) begin
        mul_s1 <= $signed(mul_a) * $signed(mul_b);
        mul_s2 <= mul_s1;
    end
    assign mul_p = mul_s2;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int gid(input int k);
        if (k < grant_id_log.size()) return grant_id_log[k];
        return -1;
    endfunction

    function automatic int gcyc(input int k);
        if (k < grant_cyc.size()) return grant_cyc[k];
        return -1;
    endfunction

    function automatic int rid(input int k);
        if (k < rsp_id_log.size()) return rsp_id_log[k];
        return -1;
    endfunction

    function automatic int rcyc(input int k);
        if (k < rsp_cyc.size()) return rsp_cyc[k];
        return -1;
    endfunction

    function automatic logic [63:0] rprod(input int k);
        if (k < rsp_prod_log.size()) return rsp_prod_log[k];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    // Requester driver: each requester presents the head of its op queue until accepted.
    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_q[i].size() > 0) begin
                    req_valid[i]            = 1'b1;
                    req_a[i*WIDTH +: WIDTH] = req_q[i][0].a;
                    req_b[i*WIDTH +: WIDTH] = req_q[i][0].b;
                end else begin
                    req_valid[i]            = 1'b0;
                    req_a[i*WIDTH +: WIDTH] = '0;
                    req_b[i*WIDTH +: WIDTH] = '0;
                end
            end
        end
    end

    // Transaction model: credit = outstanding ops, responses visible MUL_LAT+1 cycles after issue,
    // round-robin from the slot after the last winner. Compared against the DUT every cycle.
    always @(negedge clk) begin
        logic              exp_v;
        logic [NUM_REQ-1:0] exp_ready;
        logic [31:0]       a, b;
        logic signed [63:0] sa, sb;
        int                cnt, win, j;
        if (cyc >= 1) begin
            exp_v = (model_q.size() > 0) && (model_q[0].arr <= cyc);
            if (rst) begin
                checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(exp_v));
                checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
                model_q.delete();
                model_rr = 0;
            end else begin
                checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_v));
                if (exp_v) begin
                    checkOutput("rsp_id", 64'(rsp_id), 64'(model_q[0].id));
                    checkOutput("rsp_product", rsp_product, model_q[0].prod);
                end
                cnt = model_q.size();
                if (exp_v && rsp_ready) model_q.pop_front();
                win = -1;
                if (cnt < RSP_DEPTH) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        j = (model_rr + k) % NUM_REQ;
                        if (win < 0 && req_valid[j]) win = j;
                    end
                end
                exp_ready = '0;
                if (win >= 0) exp_ready[win] = 1'b1;
                checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
                if (win >= 0) begin
                    a  = req_a[win*WIDTH +: WIDTH];
                    b  = req_b[win*WIDTH +: WIDTH];
                    checkOutput("mul_a", 64'(mul_a), 64'(a));
                    checkOutput("mul_b", 64'(mul_b), 64'(b));
                    sa = $signed(a);
                    sb = $signed(b);
                    model_q.push_back('{cyc + MUL_LAT + 1, win, sa * sb});
                    model_rr = (win + 1) % NUM_REQ;
                end else begin
                    checkOutput("mul_a_idle", 64'(mul_a), 64'd0);
                    checkOutput("mul_b_idle", 64'(mul_b), 64'd0);
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        grant_cyc.push_back(cyc);
                        grant_id_log.push_back(i);
                        if (req_q[i].size() > 0) void'(req_q[i].pop_front());
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_cyc.push_back(cyc);
                    rsp_id_log.push_back(int'(rsp_id));
                    rsp_prod_log.push_back(rsp_product);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] a, input logic [31:0] b);
        req_q[id].push_back('{a, b});
    endtask

    task automatic waitIdle(input int limit);
        int   n;
        logic busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < limit) begin
            tick(1);
            n++;
            busy = (model_q.size() > 0);
            for (int i = 0; i < NUM_REQ; i++) if (req_q[i].size() > 0) busy = 1'b1;
        end
        checkOutput("idle_timeout", 64'(busy), 64'd0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g0, r0, p, r, n;
        rst       = 1'b1;
        rsp_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        #1;
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("reset_rsp_product", rsp_product, 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);

        $display("[TB] single op");
        rsp_ready = 1'b1;
        g0 = grant_cyc.size();
        r0 = rsp_cyc.size();
        applyStimulus(2, 32'd7, 32'hFFFF_FFFD);
        waitIdle(50);
        checkInt("single_grant_id", gid(g0), 2);
        checkInt("single_rsp_id", rid(r0), 2);
        checkOutput("single_product", rprod(r0), 64'hFFFF_FFFF_FFFF_FFEB);
        checkInt("single_latency", rcyc(r0) - gcyc(g0), 3);

        $display("[TB] four simultaneous requests");
        doReset();
        g0 = grant_cyc.size();
        r0 = rsp_cyc.size();
        for (int i = 0; i < 4; i++) applyStimulus(i, 32'(i + 1), 32'(10 * (i + 1)));
        waitIdle(50);
        for (int i = 0; i < 4; i++) begin
            checkInt("four_grant_id", gid(g0 + i), i);
            checkInt("four_grant_gap", gcyc(g0 + i) - gcyc(g0), i);
            checkInt("four_rsp_id", rid(r0 + i), i);
        end
        checkOutput("four_prod0", rprod(r0), 64'd10);
        checkOutput("four_prod1", rprod(r0 + 1), 64'd40);
        checkOutput("four_prod2", rprod(r0 + 2), 64'd90);
        checkOutput("four_prod3", rprod(r0 + 3), 64'd160);

        g0 = grant_cyc.size();
        r0 = rsp_cyc.size();
        applyStimulus(1, 32'd2, 32'd3);
        applyStimulus(1, 32'd4, 32'd5);
        applyStimulus(3, 32'd6, 32'd7);
        applyStimulus(3, 32'd8, 32'd9);
        waitIdle(50);
        checkInt("alt_grant0", gid(g0), 1);
        checkInt("alt_grant1", gid(g0 + 1), 3);
        checkInt("alt_grant2", gid(g0 + 2), 1);
        checkInt("alt_grant3", gid(g0 + 3), 3);
        checkOutput("alt_prod0", rprod(r0), 64'd6);
        checkOutput("alt_prod1", rprod(r0 + 1), 64'd42);
        checkOutput("alt_prod2", rprod(r0 + 2), 64'd20);
        checkOutput("alt_prod3", rprod(r0 + 3), 64'd72);

        $display("[TB] signed corners");
        r0 = rsp_cyc.size();
        applyStimulus(0, 32'h8000_0000, 32'h8000_0000);
        applyStimulus(0, 32'h8000_0000, 32'h0000_0001);
        applyStimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitIdle(50);
        checkOutput("corner_minmin", rprod(r0), 64'h4000_0000_0000_0000);
        checkOutput("corner_minone", rprod(r0 + 1), 64'hFFFF_FFFF_8000_0000);
        checkOutput("corner_negneg", rprod(r0 + 2), 64'd1);

        $display("[TB] backpressure and full credit");
        doReset();
        rsp_ready = 1'b0;
        g0 = grant_cyc.size();
        r0 = rsp_cyc.size();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) applyStimulus(i, 32'(i + 1), 32'(k + 1));
        tick(10);
        #1;
        checkInt("bp_issue_count", grant_cyc.size() - g0, 4);
        checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
        checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("bp_head_id", 64'(rsp_id), 64'd0);
        checkOutput("bp_head_product", rsp_product, 64'd1);
        tick(3);
        #1;
        checkOutput("bp_hold_valid", 64'(rsp_valid), 64'd1);
        checkOutput("bp_hold_id", 64'(rsp_id), 64'd0);
        checkOutput("bp_hold_product", rsp_product, 64'd1);
        rsp_ready = 1'b1;
        p = cyc;
        tick(1);
        rsp_ready = 1'b0;
        tick(1);
        #1;
        checkInt("bp_pulse_issue_count", grant_cyc.size() - g0, 5);
        checkInt("bp_pulse_issue_cycle", gcyc(g0 + 4), p + 1);
        checkInt("bp_pulse_issue_id", gid(g0 + 4), 0);
        checkOutput("bp_refull_req_ready", 64'(req_ready), 64'd0);
        checkOutput("bp_new_head_id", 64'(rsp_id), 64'd1);
        checkOutput("bp_new_head_product", rsp_product, 64'd2);
        rsp_ready = 1'b1;
        r = cyc;
        waitIdle(100);
        checkInt("sat_issue_total", grant_cyc.size() - g0, 16);
        checkInt("sat_first_issue", gcyc(g0 + 5), r + 1);
        for (int k = 6; k < 16; k++) checkInt("sat_issue_gap", gcyc(g0 + k) - gcyc(g0 + k - 1), 1);
        checkInt("sat_rsp_total", rsp_cyc.size() - r0, 16);
        for (int k = 2; k < 16; k++) checkInt("sat_rsp_gap", rcyc(r0 + k) - rcyc(r0 + k - 1), 1);

        $display("[TB] reset mid-flight");
        doReset();
        rsp_ready = 1'b1;
        g0 = grant_cyc.size();
        r0 = rsp_cyc.size();
        applyStimulus(1, 32'd5, 32'd5);
        applyStimulus(2, 32'd6, 32'd6);
        applyStimulus(2, 32'd7, 32'd7);
        n = 0;
        while (grant_cyc.size() - g0 < 2 && n < 20) begin
            tick(1);
            n++;
        end
        checkInt("mid_issues_before_rst", grant_cyc.size() - g0, 2);
        rst = 1'b1;
        applyStimulus(0, 32'd3, 32'd3);
        applyStimulus(3, 32'd4, 32'd4);
        #1;
        checkOutput("mid_rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        tick(1);
        rst = 1'b0;
        waitIdle(50);
        checkInt("mid_post_grant_first", gid(g0 + 2), 0);
        checkInt("mid_post_grant_second", gid(g0 + 3), 2);
        checkInt("mid_rsp_count", rsp_cyc.size() - r0, 3);
        checkInt("mid_rsp0_id", rid(r0), 0);
        checkOutput("mid_rsp0_product", rprod(r0), 64'd9);
        checkOutput("mid_rsp1_product", rprod(r0 + 1), 64'd49);
        checkOutput("mid_rsp2_product", rprod(r0 + 2), 64'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
